// File: rtl/axi4_lite_reg_pkg.sv
// Shared types, response codes and helpers for the AXI4-Lite register bank.
package axi4_lite_reg_pkg;

  // Upper bound on bank size; the type map is widened to this for lookup.
  localparam int unsigned MAX_REGS = 256;

  typedef enum logic [1:0] {
    REG_RW   = 2'd0,
    REG_RO   = 2'd1,
    REG_CMD  = 2'd2,
    REG_RSVD = 2'd3
  } reg_type_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Width of the register index field; a one-register bank still gets one bit.
  function automatic int unsigned idx_width(input int unsigned nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

  // Type of register idx from the packed 2-bit-per-register type map.
  function automatic reg_type_t get_reg_type(input logic [2*MAX_REGS-1:0] types,
                                             input int unsigned          idx);
    return reg_type_t'(types[2*idx +: 2]);
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank_if.sv
// AXI4-Lite bus bundle between the interconnect master and the register bank.
interface axi4_lite_reg_bank_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_decode.sv
// Combinational address decode: byte address -> register index, type, mapped flag.
module axi4_lite_reg_decode
  import axi4_lite_reg_pkg::*;
#(
  parameter int                          AXI_DATA_WIDTH_P = 32,
  parameter int                          AXI_ADDR_WIDTH_P = 12,
  parameter int                          NR_OF_REGS_P     = 16,
  parameter logic [2*NR_OF_REGS_P-1:0]   REG_TYPES_P      = '0
) (
  input  logic [AXI_ADDR_WIDTH_P-1:0]           i_addr,
  output logic [idx_width(NR_OF_REGS_P)-1:0]    o_idx,
  output logic                                  o_mapped,
  output reg_type_t                             o_type
);
  localparam int unsigned IDX_W_C    = idx_width(NR_OF_REGS_P);
  localparam int unsigned ADDR_LSB_C = $clog2(AXI_DATA_WIDTH_P / 8);
  localparam logic [2*MAX_REGS-1:0] TYPES_EXT_C = (2*MAX_REGS)'(REG_TYPES_P);

  // Slice the index, look up its type, and reject out-of-range or reserved slots.
  always_comb begin
    // NOTE: every output is assigned unconditionally first, so no latch can be inferred.
    o_idx    = i_addr[ADDR_LSB_C +: IDX_W_C];
    o_type   = get_reg_type(TYPES_EXT_C, 32'(o_idx));
    o_mapped = ((i_addr >> (ADDR_LSB_C + IDX_W_C)) == '0) &&
               (32'(o_idx) < 32'(NR_OF_REGS_P)) &&
               (o_type != REG_RSVD);
  end
endmodule

// File: rtl/axi4_lite_reg_bank.sv
// Parametrised AXI4-Lite register bank with RW, RO and CMD (pulse) registers.
module axi4_lite_reg_bank
  import axi4_lite_reg_pkg::*;
#(
  parameter int                                          AXI_DATA_WIDTH_P = 32,
  parameter int                                          AXI_ADDR_WIDTH_P = 12,
  parameter int                                          NR_OF_REGS_P     = 16,
  parameter logic [2*NR_OF_REGS_P-1:0]                   REG_TYPES_P      = '0,
  parameter logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]    RESET_VALUES_P   = '0
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  axi4_lite_reg_bank_if.slave                         s_axi,
  output logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]    o_cr_regs,
  input  logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]    i_sr_regs,
  output logic [NR_OF_REGS_P-1:0]                     o_cmd_pulse
);
  localparam int unsigned DW_C     = AXI_DATA_WIDTH_P;
  localparam int unsigned STRB_W_C = DW_C / 8;
  localparam int unsigned IDX_W_C  = idx_width(NR_OF_REGS_P);
  localparam logic [2*MAX_REGS-1:0] TYPES_EXT_C = (2*MAX_REGS)'(REG_TYPES_P);

  logic                        r_en;
  logic                        r_aw_full;
  logic [AXI_ADDR_WIDTH_P-1:0] r_aw_addr;
  logic                        r_w_full;
  logic [DW_C-1:0]             r_w_data;
  logic [STRB_W_C-1:0]         r_w_strb;
  logic                        r_bvalid;
  logic [1:0]                  r_bresp;
  logic                        r_rvalid;
  logic [1:0]                  r_rresp;
  logic [DW_C-1:0]             r_rdata;
  logic [DW_C-1:0]             r_cr [NR_OF_REGS_P];
  logic [NR_OF_REGS_P-1:0]     r_cmd_pulse;

  logic                        w_aw_hs, w_w_hs, w_ar_hs, w_exec;
  logic [AXI_ADDR_WIDTH_P-1:0] w_wr_addr;
  logic [DW_C-1:0]             w_wr_data, w_wr_mask, w_rd_data;
  logic [STRB_W_C-1:0]         w_wr_strb;
  logic [IDX_W_C-1:0]          w_wr_idx, w_rd_idx;
  logic                        w_wr_mapped, w_rd_mapped;
  reg_type_t                   w_wr_type, w_rd_type;
  logic [1:0]                  w_rd_resp;

  // Ready is held low through reset and for the reset cycle itself via r_en.
  assign s_axi.awready = r_en & ~r_aw_full;
  assign s_axi.wready  = r_en & ~r_w_full;
  assign s_axi.arready = r_en & ~r_rvalid;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;
  assign o_cmd_pulse   = r_cmd_pulse;

  assign w_aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_w_hs  = s_axi.wvalid  & s_axi.wready;
  assign w_ar_hs = s_axi.arvalid & s_axi.arready;

  // A channel arriving this cycle bypasses its empty hold so the write lands next cycle.
  assign w_wr_addr = r_aw_full ? r_aw_addr : s_axi.awaddr;
  assign w_wr_data = r_w_full  ? r_w_data  : s_axi.wdata;
  assign w_wr_strb = r_w_full  ? r_w_strb  : s_axi.wstrb;
  assign w_exec    = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~r_bvalid;

  axi4_lite_reg_decode #(
    .AXI_DATA_WIDTH_P (AXI_DATA_WIDTH_P),
    .AXI_ADDR_WIDTH_P (AXI_ADDR_WIDTH_P),
    .NR_OF_REGS_P     (NR_OF_REGS_P),
    .REG_TYPES_P      (REG_TYPES_P)
  ) u_aw_decode (
    .i_addr   (w_wr_addr),
    .o_idx    (w_wr_idx),
    .o_mapped (w_wr_mapped),
    .o_type   (w_wr_type)
  );

  axi4_lite_reg_decode #(
    .AXI_DATA_WIDTH_P (AXI_DATA_WIDTH_P),
    .AXI_ADDR_WIDTH_P (AXI_ADDR_WIDTH_P),
    .NR_OF_REGS_P     (NR_OF_REGS_P),
    .REG_TYPES_P      (REG_TYPES_P)
  ) u_ar_decode (
    .i_addr   (s_axi.araddr),
    .o_idx    (w_rd_idx),
    .o_mapped (w_rd_mapped),
    .o_type   (w_rd_type)
  );

  // Expand byte strobes into a bit mask and flatten the register array.
  always_comb begin
    w_wr_mask = '0;
    o_cr_regs = '0;
    for (int b = 0; b < int'(STRB_W_C); b++) w_wr_mask[8*b +: 8] = {8{w_wr_strb[b]}};
    for (int i = 0; i < NR_OF_REGS_P; i++) o_cr_regs[i*DW_C +: DW_C] = r_cr[i];
  end

  // Read data mux: RW -> control value, RO -> status input, CMD -> 0, unmapped -> SLVERR.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = AXI_RESP_SLVERR;
    if (w_rd_mapped) begin
      w_rd_resp = AXI_RESP_OKAY;
      case (w_rd_type)
        REG_RW:  w_rd_data = r_cr[w_rd_idx];
        REG_RO:  w_rd_data = i_sr_regs[w_rd_idx*DW_C +: DW_C];
        default: w_rd_data = '0;
      endcase
    end
  end

  // Channel control: hold flags, B and R response registers.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (i_rst) begin
      r_en      <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= AXI_RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_exec)       r_aw_full <= 1'b0;
      else if (w_aw_hs) r_aw_full <= 1'b1;
      if (w_exec)       r_w_full  <= 1'b0;
      else if (w_w_hs)  r_w_full  <= 1'b1;
      if (w_exec) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wr_mapped && w_wr_type != REG_RO) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (s_axi.bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rd_resp;
        r_rdata  <= w_rd_data;
      end else if (s_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Payload capture into the one-entry holds.
  always_ff @(posedge i_clk) begin
    // NOTE: payload holds have no reset; the full flags decide whether they are meaningful.
    if (w_aw_hs) r_aw_addr <= s_axi.awaddr;
    if (w_w_hs) begin
      r_w_data <= s_axi.wdata;
      r_w_strb <= s_axi.wstrb;
    end
  end

  // Register array: RW byte-lane updates, CMD one-cycle load plus pulse.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NR_OF_REGS_P; i++) begin
      if (i_rst) begin
        r_cr[i]        <= (get_reg_type(TYPES_EXT_C, i) == REG_RW) ? RESET_VALUES_P[i*DW_C +: DW_C] : '0;
        r_cmd_pulse[i] <= 1'b0;
      end else begin
        r_cmd_pulse[i] <= 1'b0;
        if (get_reg_type(TYPES_EXT_C, i) == REG_CMD) r_cr[i] <= '0;
        if (w_exec && w_wr_mapped && w_wr_idx == IDX_W_C'(i)) begin
          case (w_wr_type)
            REG_RW:  r_cr[i] <= (r_cr[i] & ~w_wr_mask) | (w_wr_data & w_wr_mask);
            REG_CMD: begin
              r_cr[i]        <= w_wr_data & w_wr_mask;
              r_cmd_pulse[i] <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule
